// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared load/store size codes and LSU state type
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_fmt.sv
// rtl/riscv_lsu_fmt.sv - byte enables, write lanes, load extract/extend and legality check
module riscv_lsu_fmt
  import riscv_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wd_lanes,
  output logic [31:0] rd_fmt,
  output logic        illegal
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = 8'(rd_word >> {addr_lo, 3'b000});
  assign rhalf = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    be       = 4'b0000;
    wd_lanes = wd;
    rd_fmt   = 32'd0;
    illegal  = 1'b0;
    case (size)
      LDST_B, LDST_BU: begin
        be       = 4'b0001 << addr_lo;
        wd_lanes = {4{wd[7:0]}};
        rd_fmt   = (size == LDST_B) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
      end
      LDST_H, LDST_HU: begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        wd_lanes = {2{wd[15:0]}};
        rd_fmt   = (size == LDST_H) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
        illegal  = addr_lo[0];
      end
      LDST_W: begin
        be       = 4'b1111;
        rd_fmt   = rd_word;
        illegal  = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit: request FSM, operand latches and memory timeout
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q, wd_q, rd_q;
  logic [2:0]    size_q;
  logic          we_q, fault_q;

  logic [2:0]    sel_size;
  logic [1:0]    sel_addr_lo;
  logic [31:0]   sel_wd;
  logic [3:0]    be;
  logic [31:0]   wd_lanes, rd_fmt;
  logic          illegal, timeout_hit, stall, mem_req;

  // Legality is judged on the live request in IDLE; afterwards only latched operands matter.
  assign sel_size    = (state_q == IDLE) ? core_size_i      : size_q;
  assign sel_addr_lo = (state_q == IDLE) ? core_addr_i[1:0] : addr_q[1:0];
  assign sel_wd      = (state_q == IDLE) ? core_wd_i        : wd_q;

  riscv_lsu_fmt u_fmt (
    .size     (sel_size),
    .addr_lo  (sel_addr_lo),
    .wd       (sel_wd),
    .rd_word  (mem_rd_i),
    .be       (be),
    .wd_lanes (wd_lanes),
    .rd_fmt   (rd_fmt),
    .illegal  (illegal)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (int'(cnt_q) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    mem_req      = 1'b0;
    core_fault_o = 1'b0;
    core_rd_o    = 32'd0;
    case (state_q)
      IDLE: begin
        stall = core_req_i;
        if (core_req_i) state_d = illegal ? RESP : BUSY;
      end
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready_i || timeout_hit) state_d = RESP;
      end
      RESP: begin
        core_fault_o = fault_q;
        core_rd_o    = rd_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is gated by reset so a held request cannot freeze the core during reset.
  assign core_stall_o = rst_ni & stall;
  assign mem_req_o    = mem_req;
  assign mem_we_o     = mem_req & we_q;
  assign mem_be_o     = mem_req ? be : 4'b0000;
  assign mem_addr_o   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wd_o     = mem_req ? wd_lanes : 32'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      size_q  <= 3'd0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core_req_i) begin
            addr_q  <= core_addr_i;
            wd_q    <= core_wd_i;
            size_q  <= core_size_i;
            we_q    <= core_we_i;
            fault_q <= illegal;
            rd_q    <= 32'd0;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            if (!we_q) rd_q <= rd_fmt;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - scoreboard bench for riscv_lsu (default and no-timeout instances)
module tb_riscv_lsu;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdw;
    int          delay;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        fault;
    int          stall;
    logic        mem;
  } acc_t;

  typedef struct {
    logic [31:0] rd;
    logic        fault;
    int          stall;
    logic        mem;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [2:0]  core_size = 3'd0;
  logic [31:0] core_addr = 32'd0, core_wd = 32'd0;
  logic [31:0] core_rd;
  logic        core_stall, core_fault;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd = 32'd0;

  logic        req_nt = 1'b0, ready_nt = 1'b0;
  logic [31:0] rd_nt, addr_nt, wd_nt;
  logic        stall_nt, fault_nt, mreq_nt, mwe_nt;
  logic [3:0]  be_nt;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  acc_t tbl[$];

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd), .core_stall_o(core_stall), .core_fault_o(core_fault),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  riscv_lsu #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(req_nt), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(rd_nt), .core_stall_o(stall_nt), .core_fault_o(fault_nt),
    .mem_req_o(mreq_nt), .mem_we_o(mwe_nt), .mem_be_o(be_nt),
    .mem_addr_o(addr_nt), .mem_wd_o(wd_nt),
    .mem_rd_i(mem_rd), .mem_ready_i(ready_nt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic run_access(input acc_t a);
    exp_t e;
    int   stall_n = 0;
    int   busy_n = 0;
    logic done = 1'b0;
    logic seen = 1'b0;
    e.rd = a.rd; e.fault = a.fault; e.stall = a.stall; e.mem = a.mem;
    sb.push_back(e);
    @(posedge clk); #1;
    core_we = a.we; core_size = a.size; core_addr = a.addr;
    core_wd = a.wd; mem_rd = a.rdw; core_req = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (core_stall) stall_n++;
      if (mem_req) begin
        busy_n++;
        if (busy_n == 1) begin
          seen = 1'b1;
          chk("mem_be",   32'(mem_be), 32'(a.be));
          chk("mem_wd",   mem_wd, a.mwd);
          chk("mem_addr", mem_addr, {a.addr[31:2], 2'b00});
          chk("mem_we",   32'(mem_we), 32'(a.we));
        end
        mem_ready = (busy_n == a.delay);
      end else if (!core_stall) begin
        mem_ready = 1'b0;
        e = sb.pop_front();
        chk("core_rd",    core_rd, e.rd);
        chk("core_fault", 32'(core_fault), 32'(e.fault));
        chk("stall_len",  32'(stall_n), 32'(e.stall));
        chk("mem_seen",   32'(seen), 32'(e.mem));
        core_req = 1'b0;
        done = 1'b1;
      end
    end
    chk("resp_seen", 32'(done), 32'd1);
    if (!done) begin core_req = 1'b0; mem_ready = 1'b0; end
  endtask

  initial begin
    int busy_n;
    int fault_seen;
    //             we    size  addr          wd            rdw           dly be     mwd           rd            flt  stl mem
    tbl.push_back('{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        2, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 3,  1'b1});
    tbl.push_back('{1'b0, 3'd0, 32'h103, 32'h0,        32'h80000000, 1, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0, 2,  1'b1});
    tbl.push_back('{1'b0, 3'd4, 32'h103, 32'h0,        32'h80000000, 1, 4'h8, 32'h0,        32'h00000080, 1'b0, 2,  1'b1});
    tbl.push_back('{1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0,        1, 4'hC, 32'h12341234, 32'h0,        1'b0, 2,  1'b1});
    tbl.push_back('{1'b0, 3'd5, 32'h102, 32'h0,        32'hABCD0000, 1, 4'hC, 32'h0,        32'h0000ABCD, 1'b0, 2,  1'b1});
    tbl.push_back('{1'b0, 3'd1, 32'h100, 32'h0,        32'h12348001, 1, 4'h3, 32'h0,        32'hFFFF8001, 1'b0, 2,  1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h108, 32'h0,        32'h12345678, 3, 4'hF, 32'h0,        32'h12345678, 1'b0, 4,  1'b1});
    tbl.push_back('{1'b1, 3'd0, 32'h101, 32'h000000A5, 32'h0,        1, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0, 2,  1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h101, 32'h0,        32'h11111111, 1, 4'h0, 32'h0,        32'h0,        1'b1, 1,  1'b0});
    tbl.push_back('{1'b0, 3'd3, 32'h100, 32'h0,        32'h11111111, 1, 4'h0, 32'h0,        32'h0,        1'b1, 1,  1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h103, 32'h0,        32'h11111111, 1, 4'h0, 32'h0,        32'h0,        1'b1, 1,  1'b0});
    tbl.push_back('{1'b1, 3'd6, 32'h100, 32'h55,       32'h0,        1, 4'h0, 32'h0,        32'h0,        1'b1, 1,  1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h104, 32'h0,        32'hFFFFFFFF, 0, 4'hF, 32'h0,        32'h0,        1'b1, 17, 1'b1});

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall",   32'(core_stall), 32'd0);
    chk("rst_fault",   32'(core_fault), 32'd0);
    chk("rst_rd",      core_rd, 32'd0);
    chk("rst_be",      32'(mem_be), 32'd0);
    chk("rst_addr",    mem_addr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (tbl[i]) run_access(tbl[i]);

    // Reset asserted in the middle of a BUSY access with the request still held.
    @(posedge clk); #1;
    core_we = 1'b1; core_size = 3'd2; core_addr = 32'h200; core_wd = 32'hCAFEF00D; core_req = 1'b1;
    busy_n = 0;
    for (int cyc = 0; cyc < 20 && busy_n < 3; cyc++) begin
      @(negedge clk);
      if (mem_req) busy_n++;
    end
    chk("pre_rst_busy", 32'(busy_n), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   32'(mem_req), 32'd0);
    chk("mid_rst_stall", 32'(core_stall), 32'd0);
    chk("mid_rst_be",    32'(mem_be), 32'd0);
    @(posedge clk); #1 core_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req",   32'(mem_req), 32'd0);
    chk("post_rst_stall", 32'(core_stall), 32'd0);
    run_access(tbl[0]);
    run_access(tbl[1]);

    // No-timeout instance keeps waiting, then completes when memory finally answers.
    @(posedge clk); #1;
    core_we = 1'b0; core_size = 3'd2; core_addr = 32'h104; mem_rd = 32'h0BADCAFE; req_nt = 1'b1;
    fault_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (fault_nt) fault_seen++;
    end
    chk("nt_stall_held", 32'(stall_nt), 32'd1);
    chk("nt_mem_req",    32'(mreq_nt), 32'd1);
    chk("nt_no_fault",   32'(fault_seen), 32'd0);
    ready_nt = 1'b1;
    @(negedge clk);
    ready_nt = 1'b0;
    chk("nt_resp_stall", 32'(stall_nt), 32'd0);
    chk("nt_resp_fault", 32'(fault_nt), 32'd0);
    chk("nt_resp_rd",    rd_nt, 32'h0BADCAFE);
    req_nt = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
